// File: rtl/timedate_pkg.sv
// Shared field map, encodings and helpers for the BCD time/date counter.
// Bit positions match the 44-bit timeAndDate vector used by source and display.
package timedate_pkg;

  localparam int SEC_LO_LSB  = 0;
  localparam int SEC_LO_MSB  = 3;
  localparam int SEC_HI_LSB  = 4;
  localparam int SEC_HI_MSB  = 6;
  localparam int MIN_LO_LSB  = 7;
  localparam int MIN_LO_MSB  = 10;
  localparam int MIN_HI_LSB  = 11;
  localparam int MIN_HI_MSB  = 13;
  localparam int HOUR_LO_LSB = 14;
  localparam int HOUR_LO_MSB = 17;
  localparam int HOUR_HI_LSB = 18;
  localparam int HOUR_HI_MSB = 19;
  localparam int DAY_LO_LSB  = 20;
  localparam int DAY_LO_MSB  = 23;
  localparam int DAY_HI_LSB  = 24;
  localparam int DAY_HI_MSB  = 25;
  localparam int MON_LO_LSB  = 26;
  localparam int MON_LO_MSB  = 29;
  localparam int MON_HI      = 30;
  localparam int YEAR_LO_LSB = 31;
  localparam int YEAR_LO_MSB = 34;
  localparam int YEAR_HI_LSB = 35;
  localparam int YEAR_HI_MSB = 38;
  localparam int WDAY_LSB    = 39;
  localparam int WDAY_MSB    = 41;
  localparam int TZ_LSB      = 42;
  localparam int TZ_MSB      = 43;

  typedef enum logic [2:0] {
    WD_NONE = 3'd0, MON = 3'd1, TUE = 3'd2, WED = 3'd3,
    THU = 3'd4, FRI = 3'd5, SAT = 3'd6, SUN = 3'd7
  } weekday_t;

  typedef enum logic [7:0] {
    LEN28 = 8'h28, LEN29 = 8'h29, LEN30 = 8'h30, LEN31 = 8'h31
  } month_len_t;

  // 00:00:00, 2000-01-01, Saturday, timezone 0
  localparam logic [43:0] TIMEDATE_RESET =
    {2'b00, SAT, 8'h00, 5'h01, 6'h01, 6'h00, 7'h00, 7'h00};

  // One BCD digit step: returns {carry, digit}; digits at or above lim wrap to 0.
  function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic [3:0] lim,
                                          input logic en);
    if (!en) return {1'b0, d};
    if (d >= lim) return 5'b1_0000;
    return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/month_length.sv
// Combinational BCD day count for a BCD month/year; Feb is 29 in years divisible
// by 4 only when TIMEDATE_LEAPYEAR_EN is defined, otherwise always 28.
module month_length
  import timedate_pkg::*;
(
  input  logic [4:0] month,
  input  logic [7:0] year,
  output logic [7:0] days
);

  logic [7:0] feb_len;

`ifdef TIMEDATE_LEAPYEAR_EN
  logic leap;
  logic unused_year_hi;

  // divisible by 4 in BCD: even tens with 0/4/8, odd tens with 2/6
  assign leap = year[4] ? (year[3:0] == 4'd2 || year[3:0] == 4'd6)
                        : (year[3:0] == 4'd0 || year[3:0] == 4'd4 || year[3:0] == 4'd8);
  assign unused_year_hi = ^year[7:5];
  assign feb_len = leap ? LEN29 : LEN28;
`else
  logic unused_year;

  assign unused_year = ^year;
  assign feb_len = LEN28;
`endif

  always_comb begin
    days = LEN31;
    case (month)
      5'h02:                      days = feb_len;
      5'h04, 5'h06, 5'h09, 5'h11: days = LEN30;
      default:                    days = LEN31;
    endcase
  end

endmodule

// File: rtl/time_date_counter.sv
// BCD clock/calendar register: load or advance by one second per secTick, full
// carry chain in one cycle; leap years honoured when TIMEDATE_LEAPYEAR_EN is defined.
module time_date_counter
  import timedate_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        secTick,
  input  logic        load,
  input  logic [43:0] timeAndDate_In,
  output logic [43:0] timeAndDate_Out,
  output logic        minuteStrobe
);

  logic [43:0] tad;
  logic [43:0] nxt;
  logic [7:0]  mlen;
  logic [4:0]  r;
  logic        sec_wrap;
  logic        hour_carry;
  logic        day_carry;
  logic        mon_carry;
  logic        year_carry;
  logic [2:0]  wd;

  month_length u_month_length (
    .month ({tad[MON_HI], tad[MON_LO_MSB:MON_LO_LSB]}),
    .year  ({tad[YEAR_HI_MSB:YEAR_HI_LSB], tad[YEAR_LO_MSB:YEAR_LO_LSB]}),
    .days  (mlen)
  );

  // nxt is always the "tick" successor of tad; the register picks it only on secTick
  always_comb begin
    nxt        = tad;
    day_carry  = 1'b0;
    mon_carry  = 1'b0;
    year_carry = 1'b0;
    wd         = tad[WDAY_MSB:WDAY_LSB];

    r = bcd_step(tad[SEC_LO_MSB:SEC_LO_LSB], 4'd9, 1'b1);
    nxt[SEC_LO_MSB:SEC_LO_LSB] = r[3:0];
    r = bcd_step({1'b0, tad[SEC_HI_MSB:SEC_HI_LSB]}, 4'd5, r[4]);
    nxt[SEC_HI_MSB:SEC_HI_LSB] = r[2:0];
    sec_wrap = r[4];

    r = bcd_step(tad[MIN_LO_MSB:MIN_LO_LSB], 4'd9, sec_wrap);
    nxt[MIN_LO_MSB:MIN_LO_LSB] = r[3:0];
    r = bcd_step({1'b0, tad[MIN_HI_MSB:MIN_HI_LSB]}, 4'd5, r[4]);
    nxt[MIN_HI_MSB:MIN_HI_LSB] = r[2:0];
    hour_carry = r[4];

    if (hour_carry) begin
      if (tad[HOUR_HI_MSB:HOUR_HI_LSB] > 2'd2 ||
          (tad[HOUR_HI_MSB:HOUR_HI_LSB] == 2'd2 && tad[HOUR_LO_MSB:HOUR_LO_LSB] >= 4'd3)) begin
        nxt[HOUR_HI_MSB:HOUR_HI_LSB] = 2'd0;
        nxt[HOUR_LO_MSB:HOUR_LO_LSB] = 4'd0;
        day_carry = 1'b1;
      end else begin
        r = bcd_step(tad[HOUR_LO_MSB:HOUR_LO_LSB], 4'd9, 1'b1);
        nxt[HOUR_LO_MSB:HOUR_LO_LSB] = r[3:0];
        nxt[HOUR_HI_MSB:HOUR_HI_LSB] = tad[HOUR_HI_MSB:HOUR_HI_LSB] + {1'b0, r[4]};
      end
    end

    if (day_carry) begin
      if ({2'b00, tad[DAY_HI_MSB:DAY_HI_LSB], tad[DAY_LO_MSB:DAY_LO_LSB]} >= mlen) begin
        nxt[DAY_HI_MSB:DAY_HI_LSB] = 2'd0;
        nxt[DAY_LO_MSB:DAY_LO_LSB] = 4'd1;
        mon_carry = 1'b1;
      end else begin
        r = bcd_step(tad[DAY_LO_MSB:DAY_LO_LSB], 4'd9, 1'b1);
        nxt[DAY_LO_MSB:DAY_LO_LSB] = r[3:0];
        nxt[DAY_HI_MSB:DAY_HI_LSB] = tad[DAY_HI_MSB:DAY_HI_LSB] + {1'b0, r[4]};
      end
      // weekday 0 is treated as Sunday so it recovers to Monday
      nxt[WDAY_MSB:WDAY_LSB] = (wd == 3'd0 || wd >= SUN) ? MON : wd + 3'd1;
    end

    if (mon_carry) begin
      if ({3'b000, tad[MON_HI], tad[MON_LO_MSB:MON_LO_LSB]} >= 8'h12) begin
        nxt[MON_HI] = 1'b0;
        nxt[MON_LO_MSB:MON_LO_LSB] = 4'd1;
        year_carry = 1'b1;
      end else begin
        r = bcd_step(tad[MON_LO_MSB:MON_LO_LSB], 4'd9, 1'b1);
        nxt[MON_LO_MSB:MON_LO_LSB] = r[3:0];
        nxt[MON_HI] = tad[MON_HI] | r[4];
      end
    end

    r = bcd_step(tad[YEAR_LO_MSB:YEAR_LO_LSB], 4'd9, year_carry);
    nxt[YEAR_LO_MSB:YEAR_LO_LSB] = r[3:0];
    r = bcd_step(tad[YEAR_HI_MSB:YEAR_HI_LSB], 4'd9, r[4]);
    nxt[YEAR_HI_MSB:YEAR_HI_LSB] = r[3:0];

    nxt[TZ_MSB:TZ_LSB] = tad[TZ_MSB:TZ_LSB];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tad          <= TIMEDATE_RESET;
      minuteStrobe <= 1'b0;
    end else if (load) begin
      tad          <= timeAndDate_In;
      minuteStrobe <= 1'b0;
    end else if (secTick) begin
      tad          <= nxt;
      minuteStrobe <= sec_wrap;
    end else begin
      minuteStrobe <= 1'b0;
    end
  end

  assign timeAndDate_Out = tad;

endmodule
